// File: rtl/seg_disp_pkg.sv
// ============================================================================
// Module   : seg_disp_pkg
// Brief    : Shared types and constants for the display scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg_disp_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam int NREQ    = 3;
  localparam int OWNER_W = 2;

  localparam logic [OWNER_W-1:0] CH_ERR = 2'd0;
  localparam logic [OWNER_W-1:0] CH_RX  = 2'd1;
  localparam logic [OWNER_W-1:0] CH_TX  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/seg_rr_pick.sv
// ============================================================================
// Module   : seg_rr_pick
// Brief    : Combinational round-robin picker; searches last+1..last+3 mod 3.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_rr_pick
  import seg_disp_pkg::*;
(
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] last,
  output logic               valid,
  output logic [OWNER_W-1:0] win
);

  logic [OWNER_W-1:0] w_cand;

  // Walk the search order backwards so the earliest candidate wins.
  always_comb begin
    valid  = |req;
    win    = CH_ERR;
    w_cand = CH_ERR;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = OWNER_W'((int'(last) + k) % NREQ);
      if (req[w_cand]) begin
        win = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_disp_sched.sv
// ============================================================================
// Module   : seg_disp_sched
// Brief    : Round-robin display scheduler with dwell timer and ch0 preemption.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_disp_sched
  import seg_disp_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int CW    = 16
) (
  input  logic               cclk,
  input  logic               clr,
  input  logic [NREQ-1:0]    req,
  input  logic [15:0]        data0,
  input  logic [15:0]        data1,
  input  logic [15:0]        data2,
  output logic [NREQ-1:0]    ack,
  output logic [15:0]        x,
  output logic [OWNER_W-1:0] owner,
  output logic               busy
);

  localparam logic [CW-1:0] c_DWELL_M1 = CW'(DWELL - 1);

  state_t             r_state, w_state_n;
  logic [CW-1:0]      r_cnt, w_cnt_n;
  logic [OWNER_W-1:0] r_last, w_last_n;
  logic [OWNER_W-1:0] r_owner, w_owner_n;
  logic [15:0]        r_x, w_x_n;
  logic [NREQ-1:0]    r_ack, w_ack_n;
  logic               r_busy;

  logic               w_valid;
  logic [OWNER_W-1:0] w_win;
  logic               w_grant;
  logic [OWNER_W-1:0] w_gch;

  seg_rr_pick u_pick (
    .req   (req),
    .last  (r_last),
    .valid (w_valid),
    .win   (w_win)
  );

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_last_n  = r_last;
    w_owner_n = r_owner;
    w_x_n     = r_x;
    w_ack_n   = '0;
    w_grant   = 1'b0;
    w_gch     = w_win;

    case (r_state)
      IDLE: begin
        w_grant = w_valid;
      end
      SHOW: begin
        w_cnt_n = r_cnt - 1'b1;
        // Channel 0 cuts in on any other owner, whatever the dwell count.
        if ((r_owner != CH_ERR) && req[CH_ERR]) begin
          w_grant = 1'b1;
          w_gch   = CH_ERR;
        end else if (r_cnt == '0) begin
          w_grant = w_valid;
          if (!w_valid) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
          end
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase

    if (w_grant) begin
      w_state_n = SHOW;
      w_cnt_n   = c_DWELL_M1;
      w_last_n  = w_gch;
      w_owner_n = w_gch;
      w_ack_n   = NREQ'(1) << w_gch;
      case (w_gch)
        CH_ERR:  w_x_n = data0;
        CH_RX:   w_x_n = data1;
        default: w_x_n = data2;
      endcase
    end
  end

  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= CH_TX;
      r_owner <= CH_ERR;
      r_x     <= 16'h0000;
      r_ack   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_last  <= w_last_n;
      r_owner <= w_owner_n;
      r_x     <= w_x_n;
      r_ack   <= w_ack_n;
      r_busy  <= (w_state_n == SHOW);
    end
  end

  assign ack   = r_ack;
  assign x     = r_x;
  assign owner = r_owner;
  assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_seg_disp_sched.sv
// ============================================================================
// Module   : tb_seg_disp_sched
// Brief    : Directed scenarios plus randomized run against a dwell/age model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg_disp_sched;

  localparam int DWELL = 4;

  logic        cclk = 1'b0;
  logic        clr;
  logic [2:0]  req;
  logic [15:0] data0, data1, data2;
  logic [2:0]  ack;
  logic [15:0] x;
  logic [1:0]  owner;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference model: time since grant, round-robin memory, shown value.
  bit          m_busy;
  int          m_age;
  int          m_last;
  int          m_owner;
  logic [15:0] m_x;
  logic [2:0]  m_ack;

  seg_disp_sched #(.DWELL(DWELL), .CW(8)) dut (
    .cclk  (cclk),
    .clr   (clr),
    .req   (req),
    .data0 (data0),
    .data1 (data1),
    .data2 (data2),
    .ack   (ack),
    .x     (x),
    .owner (owner),
    .busy  (busy)
  );

  always #5 cclk = ~cclk;

  task automatic tick;
    @(posedge cclk);
    #1;
  endtask

  task automatic do_reset;
    req = 3'b000;
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
  endtask

  function automatic int rr_pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset;
    m_busy = 0; m_age = 0; m_last = 2; m_owner = 0; m_x = 16'h0000; m_ack = 3'b000;
  endtask

  // Predicts the outputs after the coming edge from the inputs present now.
  task automatic model_step;
    int g;
    g     = -1;
    m_ack = 3'b000;
    if (!m_busy) begin
      g = rr_pick(req, m_last);
    end else begin
      m_age++;
      if (m_owner != 0 && req[0]) g = 0;
      else if (m_age == DWELL) begin
        g = rr_pick(req, m_last);
        if (g < 0) m_busy = 0;
      end
    end
    if (g >= 0) begin
      m_x     = (g == 0) ? data0 : (g == 1) ? data1 : data2;
      m_ack   = 3'b001 << g;
      m_owner = g;
      m_last  = g;
      m_busy  = 1;
      m_age   = 0;
    end
  endtask

  task automatic test_reset;
    data0 = 16'h0000; data1 = 16'h0000; data2 = 16'h0000;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      total++;
      if ({x, ack, busy, owner} !== {16'h0000, 3'b000, 1'b0, 2'd0}) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got x=%h ack=%b busy=%b owner=%0d want 0000/000/0/0",
                 i, x, ack, busy, owner);
      end
      tick();
    end
  endtask

  task automatic test_single;
    do_reset();
    data1 = 16'h00A5;
    req   = 3'b010;
    tick();
    total++;
    if ({ack, x, owner, busy} !== {3'b010, 16'h00A5, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL single_grant got ack=%b x=%h owner=%0d busy=%b want 010/00a5/1/1",
               ack, x, owner, busy);
    end
    req = 3'b000;
    for (int i = 1; i < DWELL; i++) begin
      tick();
      total++;
      if ({ack, busy, x} !== {3'b000, 1'b1, 16'h00A5}) begin
        bad++;
        $display("FAIL single_dwell cyc=%0d got ack=%b busy=%b x=%h want 000/1/00a5", i, ack, busy, x);
      end
    end
    tick();
    total++;
    if ({ack, busy, x} !== {3'b000, 1'b0, 16'h00A5}) begin
      bad++;
      $display("FAIL single_idle got ack=%b busy=%b x=%h want 000/0/00a5", ack, busy, x);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0]  exp_ack [3];
    logic [15:0] exp_x   [3];
    int n;
    exp_ack[0] = 3'b001; exp_ack[1] = 3'b010; exp_ack[2] = 3'b100;
    exp_x[0] = 16'h1111; exp_x[1] = 16'h2222; exp_x[2] = 16'h3333;
    do_reset();
    data0 = 16'h1111; data1 = 16'h2222; data2 = 16'h3333;
    req   = 3'b111;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (ack == 3'b000 && n < 10);
      total++;
      if (ack !== exp_ack[i] || x !== exp_x[i] || n != ((i == 0) ? 1 : DWELL)) begin
        bad++;
        $display("FAIL rr_order idx=%0d got ack=%b x=%h gap=%0d want ack=%b x=%h gap=%0d",
                 i, ack, x, n, exp_ack[i], exp_x[i], (i == 0) ? 1 : DWELL);
      end
      req = req & ~ack;
    end
    req = 3'b000;
  endtask

  task automatic test_fairness;
    int n;
    do_reset();
    data0 = 16'hF000; data1 = 16'hF001;
    req   = 3'b010;
    tick();
    total++;
    if (ack !== 3'b010) begin
      bad++;
      $display("FAIL fair_first got ack=%b want 010", ack);
    end
    req = 3'b000;
    repeat (DWELL) tick();
    req = 3'b011;
    tick();
    total++;
    if (ack !== 3'b001 || x !== 16'hF000) begin
      bad++;
      $display("FAIL fair_ch0 got ack=%b x=%h want 001/f000", ack, x);
    end
    req = 3'b010;
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == 3'b000 && n < 10);
    total++;
    if (ack !== 3'b010 || n != DWELL) begin
      bad++;
      $display("FAIL fair_ch1 got ack=%b gap=%0d want 010 gap=%0d", ack, n, DWELL);
    end
    req = 3'b000;
  endtask

  task automatic test_preempt;
    do_reset();
    data2 = 16'h1234;
    req   = 3'b100;
    tick();
    total++;
    if (ack !== 3'b100 || x !== 16'h1234) begin
      bad++;
      $display("FAIL pre_grant2 got ack=%b x=%h want 100/1234", ack, x);
    end
    req = 3'b000;
    tick();
    data0 = 16'hE001;
    req   = 3'b001;
    tick();
    total++;
    if ({ack, x, owner, busy} !== {3'b001, 16'hE001, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL pre_take got ack=%b x=%h owner=%0d busy=%b want 001/e001/0/1",
               ack, x, owner, busy);
    end
    req = 3'b000;
    for (int i = 1; i < DWELL; i++) begin
      tick();
      total++;
      if (busy !== 1'b1 || ack !== 3'b000) begin
        bad++;
        $display("FAIL pre_reload cyc=%0d got busy=%b ack=%b want 1/000", i, busy, ack);
      end
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL pre_end got busy=%b want 0", busy);
    end
  endtask

  task automatic test_no_self_preempt;
    logic [2:0] exp_a;
    do_reset();
    data0 = 16'h00E0;
    req   = 3'b001;
    tick();
    req = 3'b000;
    tick();
    data0 = 16'h00E1;
    req   = 3'b001;
    for (int i = 2; i <= DWELL; i++) begin
      tick();
      exp_a = (i == DWELL) ? 3'b001 : 3'b000;
      total++;
      if (ack !== exp_a || x !== ((i == DWELL) ? 16'h00E1 : 16'h00E0)) begin
        bad++;
        $display("FAIL ch0_nopre cyc=%0d got ack=%b x=%h want ack=%b", i, ack, x, exp_a);
      end
    end
    req = 3'b000;
    repeat (DWELL) tick();
  endtask

  task automatic test_async_reset;
    do_reset();
    data1 = 16'h5A5A;
    req   = 3'b010;
    tick();
    req = 3'b000;
    tick();
    #2;
    clr = 1'b1;
    #1;
    total++;
    if ({x, ack, busy, owner} !== {16'h0000, 3'b000, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL async_clr got x=%h ack=%b busy=%b owner=%0d want 0000/000/0/0",
               x, ack, busy, owner);
    end
    tick();
    tick();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({x, ack, busy} !== {16'h0000, 3'b000, 1'b0}) begin
        bad++;
        $display("FAIL async_after cyc=%0d got x=%h ack=%b busy=%b want 0000/000/0", i, x, ack, busy);
      end
    end
  endtask

  task automatic test_random;
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      model_step();
      tick();
      total++;
      if ({ack, x, owner, busy} !== {m_ack, m_x, 2'(m_owner), m_busy}) begin
        bad++;
        $display("FAIL random cyc=%0d got ack=%b x=%h owner=%0d busy=%b want ack=%b x=%h owner=%0d busy=%b",
                 cyc, ack, x, owner, busy, m_ack, m_x, m_owner, m_busy);
      end
      for (int c = 0; c < 3; c++) begin
        if (ack[c]) begin
          req[c] = 1'b0;
        end else if (!req[c] && $urandom_range(0, 5) == 0) begin
          req[c] = 1'b1;
          case (c)
            0:       data0 = 16'($urandom);
            1:       data1 = 16'($urandom);
            default: data2 = 16'($urandom);
          endcase
        end
      end
    end
    req = 3'b000;
  endtask

  initial begin
    clr   = 1'b1;
    req   = 3'b000;
    data0 = 16'h0000;
    data1 = 16'h0000;
    data2 = 16'h0000;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_preempt();
    test_no_self_preempt();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
